// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and lane helpers for the data-memory responder.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Byte lanes touched by an access; little-endian, lane 0 = bits [7:0].
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            SZ_BYTE: mask = 4'b0001 << off;
            SZ_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b11)
            || ((size == SZ_HALF) && off[0])
            || ((size == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 synchronous RAM with per-byte write enables and a registered read port.
module dmem_array #(
    parameter int DEPTH_WORDS = 64,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the storage array has no reset so it maps onto block RAM; only control state is reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with programmable wait states and byte-lane stores.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int         AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t          state, next_state;
    logic [3:0]      cnt;
    logic            we_q;
    logic [1:0]      size_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic            err_q;
    logic [31:0]     rdata_q;

    logic            cur_we;
    logic [1:0]      cur_size;
    logic [AW+1:0]   cur_addr;
    logic [31:0]     cur_wdata;
    logic [31:0]     lane_data;
    logic            bad;
    logic            access;
    logic [31:0]     dout;

    logic unused_addr;
    assign unused_addr = &{1'b0, addr[31:AW+2]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd1) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // With zero wait states the access fires on the acceptance edge, before the request is latched.
    always_comb begin
        cur_we    = we_q;
        cur_size  = size_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state == IDLE) begin
            cur_we    = we;
            cur_size  = size;
            cur_addr  = addr[AW+1:0];
            cur_wdata = wdata;
        end
    end

    always_comb begin
        case (cur_size)
            SZ_BYTE: lane_data = {4{cur_wdata[7:0]}};
            SZ_HALF: lane_data = {2{cur_wdata[15:0]}};
            default: lane_data = cur_wdata;
        endcase
    end

    assign bad    = misaligned(cur_size, cur_addr[1:0]);
    assign access = (next_state == RESP) && !reset;

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .en    (access && !bad),
        .be    (cur_we ? lane_mask(cur_size, cur_addr[1:0]) : 4'b0000),
        .idx   (cur_addr[AW+1:2]),
        .wdata (lane_data),
        .rdata (dout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            if (state == IDLE && req) begin
                we_q    <= we;
                size_q  <= size;
                addr_q  <= addr[AW+1:0];
                wdata_q <= wdata;
                cnt     <= LAT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (access)        err_q   <= bad;
            if (state == RESP) rdata_q <= rdata;
        end
    end

    // Load data is extracted from the registered array word during RESP, then held.
    always_comb begin
        rdata = rdata_q;
        if (state == RESP) begin
            if (err_q) begin
                rdata = 32'd0;
            end else if (!we_q) begin
                case (size_q)
                    SZ_BYTE: rdata = {24'd0, dout[{addr_q[1:0], 3'b000} +: 8]};
                    SZ_HALF: rdata = {16'd0, dout[{addr_q[1], 4'b0000} +: 16]};
                    default: rdata = dout;
                endcase
            end
        end
    end

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);
    assign err   = err_q;

endmodule
